// File: rtl/lcg_stream_checker.sv
// lcg_stream_checker
//   Receive-side twin of the LCG stimulus driver. It regenerates the expected
//   LCG word stream from the same seed and compares each incoming flattened
//   vector one 32-bit word per cycle.
//
//   Optional feature macro: LCG_CHECK_STOP_ON_ERR_EN
//     When defined, the first mismatch sends the FSM to HALT, which freezes
//     everything until start or reset. When undefined, checking continues
//     through errors.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            1-cycle pulse: load seed, clear counters and flags, go READY
//   seed_sel/seed_in seed_sel=0 selects SEED, seed_sel=1 selects seed_in
//   vec_valid/ready  vector handshake; vec_data word k = bits [32k+31:32k]
//   busy             high while words are being compared
//   mismatch         sticky flag, set by any mismatching word since start
//   err_count        number of mismatching words, saturating
//   vec_count        number of vectors fully checked, wrapping
//   first_err_vec    vec_count value at the first mismatch
//   first_err_word   word index of the first mismatch
module lcg_stream_checker #(
  parameter int          VEC_W = 335,
  parameter logic [31:0] SEED  = 32'd767950141,
  parameter int          CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_sel,
  input  logic [31:0]      seed_in,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [VEC_W-1:0] vec_data,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] first_err_vec,
  output logic [7:0]       first_err_word
);

  localparam int          NWORDS    = (VEC_W + 31) / 32;
  localparam int          LAST_W    = VEC_W - 32 * (NWORDS - 1);
  localparam int          PAD_W     = NWORDS * 32;
  localparam logic [31:0] LAST_MASK = 32'hFFFF_FFFF >> (32 - LAST_W);
  localparam logic [7:0]  LAST_IDX  = 8'(NWORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef LCG_CHECK_STOP_ON_ERR_EN
  typedef enum logic [1:0] {S_IDLE, S_READY, S_CHECK, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READY, S_CHECK} state_t;
`endif

  function automatic logic [31:0] lcg_nxt(input logic [31:0] s);
    return s * 32'h41C6_4E6D + 32'h0000_3039;
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      rng_q, rng_d;
  logic [PAD_W-1:0] shadow_q, shadow_d;
  logic [7:0]       idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic [CNT_W-1:0] fev_q, fev_d;
  logic [7:0]       few_q, few_d;

  // Compare datapath: the state advances before each word, so the word under
  // test is checked against nxt(rng_q), which also becomes the new state.
  logic [31:0] rng_nxt;
  logic [31:0] cur_word;
  logic [31:0] word_mask;
  logic        is_last;
  logic        word_err;

  always_comb begin
    rng_nxt   = lcg_nxt(rng_q);
    cur_word  = shadow_q[int'(idx_q) * 32 +: 32];
    is_last   = (idx_q == LAST_IDX);
    // Bits above the vector width in the final word are don't-care.
    word_mask = is_last ? LAST_MASK : 32'hFFFF_FFFF;
    word_err  = |((cur_word ^ rng_nxt) & word_mask);
  end

  always_comb begin
    state_d  = state_q;
    rng_d    = rng_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    mis_d    = mis_q;
    err_d    = err_q;
    vcnt_d   = vcnt_q;
    fev_d    = fev_q;
    few_d    = few_q;

    if (start) begin
      // Highest priority: aborts any in-flight vector and blocks acceptance.
      state_d = S_READY;
      rng_d   = seed_sel ? seed_in : SEED;
      idx_d   = '0;
      mis_d   = 1'b0;
      err_d   = '0;
      vcnt_d  = '0;
      fev_d   = '0;
      few_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_READY: begin
          if (vec_valid) begin
            shadow_d                = '0;
            shadow_d[VEC_W-1:0]     = vec_data;
            idx_d                   = '0;
            state_d                 = S_CHECK;
          end
        end
        S_CHECK: begin
          rng_d = rng_nxt;
          idx_d = idx_q + 8'd1;
          if (word_err) begin
            mis_d = 1'b1;
            err_d = (&err_q) ? err_q : err_q + CNT_ONE;
            if (!mis_q) begin
              fev_d = vcnt_q;
              few_d = idx_q;
            end
          end
          if (is_last) begin
            idx_d   = '0;
            vcnt_d  = vcnt_q + CNT_ONE;
            state_d = S_READY;
          end
`ifdef LCG_CHECK_STOP_ON_ERR_EN
          if (word_err && !mis_q) state_d = S_HALT;
`endif
        end
`ifdef LCG_CHECK_STOP_ON_ERR_EN
        S_HALT: ;
`endif
        default: state_d = S_IDLE;
      endcase
    end

    ready_d = (state_d == S_READY);
    busy_d  = (state_d == S_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rng_q    <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= '0;
      vcnt_q   <= '0;
      fev_q    <= '0;
      few_q    <= '0;
    end else begin
      state_q  <= state_d;
      rng_q    <= rng_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
      vcnt_q   <= vcnt_d;
      fev_q    <= fev_d;
      few_q    <= few_d;
    end
  end

  assign vec_ready      = ready_q;
  assign busy           = busy_q;
  assign mismatch       = mis_q;
  assign err_count      = err_q;
  assign vec_count      = vcnt_q;
  assign first_err_vec  = fev_q;
  assign first_err_word = few_q;

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Self-checking bench for lcg_stream_checker (default build).
// The reference model derives each expected vector directly from the LCG
// recurrence (word k of vector v = nxt^(v*NWORDS+k+1)(seed)) and scores the
// sent vector by XOR against it.
module tb_lcg_stream_checker;
  localparam int          VEC_W = 335;
  localparam int          CNT_W = 32;
  localparam logic [31:0] SEED  = 32'd767950141;
  localparam int          NW    = (VEC_W + 31) / 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, seed_sel, vec_valid;
  logic [31:0]      seed_in;
  logic [VEC_W-1:0] vec_data;
  logic             vec_ready, busy, mismatch;
  logic [CNT_W-1:0] err_count, vec_count, first_err_vec;
  logic [7:0]       first_err_word;

  lcg_stream_checker #(.VEC_W(VEC_W), .SEED(SEED), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_sel(seed_sel),
    .seed_in(seed_in), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .busy(busy), .mismatch(mismatch),
    .err_count(err_count), .vec_count(vec_count),
    .first_err_vec(first_err_vec), .first_err_word(first_err_word)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'd1103515245 + 32'd12345;
  endfunction

  function automatic logic [VEC_W-1:0] gen_vec(input logic [31:0] sd, input int v);
    logic [NW*32-1:0] w;
    logic [31:0] s;
    s = sd;
    w = '0;
    for (int i = 0; i < v * NW; i++) s = lcg(s);
    for (int k = 0; k < NW; k++) begin
      s = lcg(s);
      w[k*32 +: 32] = s;
    end
    return w[VEC_W-1:0];
  endfunction

  logic [31:0]      m_seed;
  int               m_v;
  logic             m_mis;
  logic [CNT_W-1:0] m_err, m_fv;
  logic [7:0]       m_fw;

  task automatic model_start(input logic [31:0] sd);
    m_seed = sd; m_v = 0; m_mis = 0; m_err = 0; m_fv = 0; m_fw = 0;
  endtask

  task automatic model_vec(input logic [VEC_W-1:0] v);
    logic [NW*32-1:0] diff;
    diff = '0;
    diff[VEC_W-1:0] = v ^ gen_vec(m_seed, m_v);
    for (int k = 0; k < NW; k++) begin
      if (diff[k*32 +: 32] != 0) begin
        if (!m_mis) begin m_fv = CNT_W'(m_v); m_fw = 8'(k); end
        m_mis = 1;
        m_err = m_err + 1;
      end
    end
    m_v++;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_vcnt"}, 64'(vec_count), 64'(m_v));
    chk({tag, "_err"},  64'(err_count), 64'(m_err));
    chk({tag, "_mis"},  64'(mismatch),  64'(m_mis));
    chk({tag, "_fv"},   64'(first_err_vec),  64'(m_fv));
    chk({tag, "_fw"},   64'(first_err_word), 64'(m_fw));
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start(input logic sel, input logic [31:0] sin);
    @(negedge clk);
    seed_sel = sel; seed_in = sin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_start(sel ? sin : SEED);
  endtask

  task automatic send_vec(input logic [VEC_W-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    vec_data = v; vec_valid = 1'b1;
    while (!vec_ready && n < 100) begin @(negedge clk); n++; end
    if (!vec_ready) chk("send_timeout", 64'(vec_ready), 64'd1);
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic send_model(input logic [VEC_W-1:0] v);
    model_vec(v);
    send_vec(v);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!vec_ready && n < 100) begin @(negedge clk); n++; end
    if (!vec_ready) chk("done_timeout", 64'(vec_ready), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(vec_ready), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_mis"},   64'(mismatch), 64'd0);
    chk({tag, "_err"},   64'(err_count), 64'd0);
    chk({tag, "_vcnt"},  64'(vec_count), 64'd0);
    chk({tag, "_fv"},    64'(first_err_vec), 64'd0);
    chk({tag, "_fw"},    64'(first_err_word), 64'd0);
  endtask

  // Throughput monitor: accept cycles and ready-low cycles between accepts.
  int cyc = 0;
  int acc_q[$];
  int lo_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (vec_ready && vec_valid) acc_q.push_back(cyc);
    else if (!vec_ready && acc_q.size() > 0 && acc_q.size() < 30) lo_cnt++;
  end

  // ---------------- stimulus ----------------
  logic [VEC_W-1:0] v;
  logic [31:0]      w1;

  initial begin
    rst_n = 1'b0; start = 1'b0; seed_sel = 1'b0; seed_in = '0;
    vec_valid = 1'b0; vec_data = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(vec_ready), 64'd0);

    // Seed 0: literal first two words from the LCG recurrence.
    pulse_start(1'b1, 32'd0);
    chk("start_ready", 64'(vec_ready), 64'd1);
    v  = gen_vec(32'd0, 0);
    w1 = 32'hD3DC167E;
    v[31:0]  = 32'h00003039;
    v[63:32] = w1;
    send_model(v);
    wait_done();
    chk("seed0_mis",  64'(mismatch), 64'd0);
    chk("seed0_vcnt", 64'(vec_count), 64'd1);
    chk("seed0_err",  64'(err_count), 64'd0);

    // 30 correct vectors back-to-back with the default seed.
    pulse_start(1'b0, 32'd0);
    acc_q.delete(); lo_cnt = 0;
    for (int i = 0; i < 30; i++) send_model(gen_vec(SEED, i));
    wait_done();
    chk("b2b_vcnt", 64'(vec_count), 64'd30);
    chk("b2b_err",  64'(err_count), 64'd0);
    chk("b2b_nacc", 64'(acc_q.size()), 64'd30);
    begin
      int bad;
      bad = 0;
      for (int i = 1; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i-1] != 12) bad++;
      chk("b2b_gap", 64'(bad), 64'd0);
    end
    chk("b2b_lowcyc", 64'(lo_cnt), 64'(29 * 11));
    chk_model("b2b");

    // Bit 5 of word 3 flipped in vector 2.
    pulse_start(1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      v = gen_vec(SEED, i);
      if (i == 2) v[3*32+5] = ~v[3*32+5];
      send_model(v);
    end
    wait_done();
    chk("flip_mis", 64'(mismatch), 64'd1);
    chk("flip_err", 64'(err_count), 64'd1);
    chk("flip_fv",  64'(first_err_vec), 64'd2);
    chk("flip_fw",  64'(first_err_word), 64'd3);
    chk("flip_vcnt", 64'(vec_count), 64'd4);

    // Top bit of the partial last word (bit 14 of word 10) is checked.
    pulse_start(1'b0, 32'd0);
    v = gen_vec(SEED, 0);
    v[VEC_W-1] = ~v[VEC_W-1];
    send_model(v);
    wait_done();
    chk("last_err", 64'(err_count), 64'd1);
    chk("last_fw",  64'(first_err_word), 64'(NW - 1));
    chk_model("last");

    // Randomized rounds against the model.
    for (int r = 0; r < 4; r++) begin
      pulse_start(1'($urandom_range(0, 1)), $urandom);
      for (int i = 0; i < int'($urandom_range(3, 6)); i++) begin
        v = gen_vec(m_seed, m_v);
        for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
          int b;
          b = int'($urandom_range(0, VEC_W - 1));
          v[b] = ~v[b];
        end
        send_model(v);
        wait_done();
        chk_model($sformatf("rnd%0d_%0d", r, i));
      end
    end

    // start mid-CHECK (idx=4): in-flight vector (bad word 0) is discarded.
    pulse_start(1'b0, 32'd0);
    v = gen_vec(SEED, 0);
    v[0] = ~v[0];
    send_vec(v);
    repeat (4) @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_mis_before", 64'(mismatch), 64'd1);
    pulse_start(1'b0, 32'd0);
    chk("abort_vcnt", 64'(vec_count), 64'd0);
    chk("abort_mis",  64'(mismatch), 64'd0);
    chk("abort_err",  64'(err_count), 64'd0);
    chk("abort_ready", 64'(vec_ready), 64'd1);
    send_model(gen_vec(SEED, 0));
    wait_done();
    chk_model("resend");

    // Async reset in the middle of a CHECK.
    send_model(gen_vec(SEED, 1));
    @(negedge clk);
    chk("arst_busy_before", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("arst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_ready", 64'(vec_ready), 64'd0);
    chk("arst_idle_busy",  64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
